wb_stage: RTL and testbench



---
 rtl/wb_stage.sv | 133 +++++++++++++
 tb/tb_wb_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: load-lane extraction, register-file write port, HI/LO pair,
// and a stall/timeout handshake for a variable-latency data-memory read.
module wb_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic [4:0]  wb_wa,
    input  logic        wb_wreg,
    input  logic [31:0] wb_dreg,
    input  logic        wb_mreg,
    input  logic [3:0]  wb_dre,
    input  logic        wb_sext,
    input  logic        wb_whilo,
    input  logic [63:0] wb_hilo,
    input  logic [31:0] dm_rdata,
    input  logic        dm_rvalid,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stall_req,
    output logic        dm_err,
    output logic        dbg_state_o
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, lo_q;
    logic        lane_ok;
    logic [31:0] ld_data;
    logic        ld_req;
    logic        wa_nz;

    // Only these enable patterns describe a real load; anything else writes nothing.
    always_comb begin
        lane_ok = 1'b1;
        ld_data = dm_rdata;
        case (wb_dre)
            4'b1111: ld_data = dm_rdata;
            4'b0001: ld_data = {{24{wb_sext & dm_rdata[7]}},  dm_rdata[7:0]};
            4'b0010: ld_data = {{24{wb_sext & dm_rdata[15]}}, dm_rdata[15:8]};
            4'b0100: ld_data = {{24{wb_sext & dm_rdata[23]}}, dm_rdata[23:16]};
            4'b1000: ld_data = {{24{wb_sext & dm_rdata[31]}}, dm_rdata[31:24]};
            4'b0011: ld_data = {{16{wb_sext & dm_rdata[15]}}, dm_rdata[15:0]};
            4'b1100: ld_data = {{16{wb_sext & dm_rdata[31]}}, dm_rdata[31:16]};
            default: lane_ok = 1'b0;
        endcase
    end

    assign ld_req = wb_mreg & wb_wreg & lane_ok;
    assign wa_nz  = (wb_wa != 5'd0);
    assign rf_wa  = wb_wa;
    assign rf_wd  = wb_mreg ? ld_data : wb_dreg;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rf_we     = 1'b0;
        stall_req = 1'b0;
        dm_err    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_req) begin
                    if (dm_rvalid) begin
                        rf_we = wa_nz;
                    end else begin
                        stall_req = 1'b1;
                        state_d   = WAIT;
                        cnt_d     = 8'd1;
                    end
                end else begin
                    rf_we = ~wb_mreg & wb_wreg & wa_nz;
                end
            end
            WAIT: begin
                if (dm_rvalid) begin
                    rf_we   = ld_req & wa_nz;
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    dm_err  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    stall_req = 1'b1;
                    cnt_d     = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        // Reset must drop the stall at once, even with a load still on the inputs.
        if (cpu_rst) begin
            rf_we     = 1'b0;
            stall_req = 1'b0;
            dm_err    = 1'b0;
        end
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A HI/LO write paired with a stalled load lands on the release cycle.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (wb_whilo && !stall_req) begin
            hi_q <= wb_hilo[63:32];
            lo_q <= wb_hilo[31:0];
        end
    end

    assign hi_o        = wb_whilo ? wb_hilo[63:32] : hi_q;
    assign lo_o        = wb_whilo ? wb_hilo[31:0]  : lo_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: register-file writes are checked by a monitor against an
// expected queue; stall, error and HI/LO behaviour are checked inline.
module tb_wb_stage;

    logic        clk;
    logic        cpu_rst;
    logic [4:0]  wb_wa;
    logic        wb_wreg;
    logic [31:0] wb_dreg;
    logic        wb_mreg;
    logic [3:0]  wb_dre;
    logic        wb_sext;
    logic        wb_whilo;
    logic [63:0] wb_hilo;
    logic [31:0] dm_rdata;
    logic        dm_rvalid;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stall_req;
    logic        dm_err;
    logic        dbg_state;

    int total = 0;
    int bad   = 0;
    logic [36:0] exp_q[$];

    wb_stage #(.TIMEOUT(4)) dut (
        .cpu_clk_50M(clk),
        .cpu_rst(cpu_rst),
        .wb_wa(wb_wa),
        .wb_wreg(wb_wreg),
        .wb_dreg(wb_dreg),
        .wb_mreg(wb_mreg),
        .wb_dre(wb_dre),
        .wb_sext(wb_sext),
        .wb_whilo(wb_whilo),
        .wb_hilo(wb_hilo),
        .dm_rdata(dm_rdata),
        .dm_rvalid(dm_rvalid),
        .rf_we(rf_we),
        .rf_wa(rf_wa),
        .rf_wd(rf_wd),
        .hi_o(hi_o),
        .lo_o(lo_o),
        .stall_req(stall_req),
        .dm_err(dm_err),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rf_write: unexpected write wa=%0d wd=%h", rf_wa, rf_wd);
            end else begin
                check("rf_write", {27'd0, rf_wa, rf_wd}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_in();
        wb_wa = 5'd0; wb_wreg = 1'b0; wb_dreg = 32'd0; wb_mreg = 1'b0;
        wb_dre = 4'd0; wb_sext = 1'b0; wb_whilo = 1'b0; wb_hilo = 64'd0;
        dm_rdata = 32'd0; dm_rvalid = 1'b0;
    endtask

    task automatic alu(input logic [4:0] wa, input logic wreg, input logic [31:0] dreg);
        idle_in();
        wb_wa = wa; wb_wreg = wreg; wb_dreg = dreg;
    endtask

    task automatic load(input logic [4:0] wa, input logic [3:0] dre, input logic sext,
                        input logic rvalid, input logic [31:0] rdata);
        idle_in();
        wb_wa = wa; wb_wreg = 1'b1; wb_mreg = 1'b1; wb_dre = dre; wb_sext = sext;
        dm_rvalid = rvalid; dm_rdata = rdata;
    endtask

    task automatic lane_load(input logic [3:0] dre, input logic sext, input logic writes,
                             input logic [31:0] exp);
        step();
        load(5'd20, dre, sext, 1'b1, 32'h80FF_7F81);
        if (writes) exp_q.push_back({5'd20, exp});
        mid();
        check("lane_stall", {63'd0, stall_req}, 64'd0);
        if (!writes) check("lane_no_write", {63'd0, rf_we}, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  stall_n;
        bit  seen;

        idle_in();
        cpu_rst = 1'b1;
        step();
        step();
        mid();
        check("rst_stall", {63'd0, stall_req}, 64'd0);
        check("rst_err", {63'd0, dm_err}, 64'd0);
        check("rst_hilo", {hi_o, lo_o}, 64'd0);
        check("rst_rf_we", {63'd0, rf_we}, 64'd0);
        check("rst_state", {63'd0, dbg_state}, 64'd0);
        step();
        cpu_rst = 1'b0;

        // ALU writes
        alu(5'd5, 1'b1, 32'h1234_5678);
        exp_q.push_back({5'd5, 32'h1234_5678});
        mid();
        step();
        alu(5'd0, 1'b1, 32'hFFFF_FFFF);
        mid();
        check("alu_wa0", {63'd0, rf_we}, 64'd0);
        step();
        alu(5'd6, 1'b0, 32'h0000_0006);
        dm_rvalid = 1'b1;
        mid();
        check("stray_rvalid", {63'd0, rf_we}, 64'd0);
        check("stray_rvalid_stall", {63'd0, stall_req}, 64'd0);

        // Lane selection on 0x80FF_7F81
        lane_load(4'b0001, 1'b1, 1'b1, 32'hFFFF_FF81);
        lane_load(4'b0010, 1'b1, 1'b1, 32'h0000_007F);
        lane_load(4'b1000, 1'b0, 1'b1, 32'h0000_0080);
        lane_load(4'b1100, 1'b1, 1'b1, 32'hFFFF_80FF);
        lane_load(4'b0100, 1'b0, 1'b1, 32'h0000_00FF);
        lane_load(4'b0011, 1'b1, 1'b1, 32'h0000_7F81);
        lane_load(4'b1111, 1'b1, 1'b1, 32'h80FF_7F81);
        lane_load(4'b0101, 1'b1, 1'b0, 32'h0);
        lane_load(4'b0000, 1'b1, 1'b0, 32'h0);

        // Read data arrives three cycles late
        step();
        load(5'd7, 4'b1111, 1'b0, 1'b0, 32'd0);
        exp_q.push_back({5'd7, 32'hCAFE_0042});
        for (int i = 0; i < 3; i++) begin
            mid();
            check("late_stall", {63'd0, stall_req}, 64'd1);
            check("late_no_write", {63'd0, rf_we}, 64'd0);
            if (i < 2) step();
        end
        step();
        dm_rdata = 32'hCAFE_0042;
        dm_rvalid = 1'b1;
        mid();
        check("late_release", {63'd0, stall_req}, 64'd0);
        step();
        idle_in();
        mid();
        check("late_idle", {63'd0, dbg_state}, 64'd0);

        // Timeout: the issue cycle plus TIMEOUT-1 WAIT cycles stall, the
        // TIMEOUT-th WAIT cycle aborts with the error pulse.
        step();
        load(5'd9, 4'b1111, 1'b0, 1'b0, 32'h0BAD_0BAD);
        stall_n = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            mid();
            if (stall_req) begin
                stall_n++;
                check("to_no_err_yet", {63'd0, dm_err}, 64'd0);
            end else begin
                seen = 1;
                check("to_err", {63'd0, dm_err}, 64'd1);
                check("to_no_write", {63'd0, rf_we}, 64'd0);
            end
            if (!seen) step();
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL to_abort: stall never released, expected release after 4 cycles");
        end
        check("to_stall_cycles", 64'(stall_n), 64'd4);
        step();
        alu(5'd3, 1'b1, 32'hA5A5_0003);
        exp_q.push_back({5'd3, 32'hA5A5_0003});
        mid();
        check("to_err_one_cycle", {63'd0, dm_err}, 64'd0);
        check("to_next_no_stall", {63'd0, stall_req}, 64'd0);

        // HI/LO bypass and store
        step();
        idle_in();
        wb_whilo = 1'b1;
        wb_hilo = 64'hDEAD_BEEF_0000_0001;
        mid();
        check("hilo_bypass", {hi_o, lo_o}, 64'hDEAD_BEEF_0000_0001);
        step();
        idle_in();
        mid();
        check("hilo_stored", {hi_o, lo_o}, 64'hDEAD_BEEF_0000_0001);

        // HI/LO write held back during a stalled load
        step();
        load(5'd10, 4'b1111, 1'b0, 1'b0, 32'd0);
        wb_whilo = 1'b1;
        wb_hilo = 64'h1111_2222_3333_4444;
        exp_q.push_back({5'd10, 32'h5555_AAAA});
        mid();
        check("hilo_stall_bypass", {hi_o, lo_o}, 64'h1111_2222_3333_4444);
        step();
        mid();
        check("hilo_held_back", {dut.hi_q, dut.lo_q}, 64'hDEAD_BEEF_0000_0001);
        step();
        dm_rdata = 32'h5555_AAAA;
        dm_rvalid = 1'b1;
        mid();
        check("hilo_release", {63'd0, stall_req}, 64'd0);
        step();
        idle_in();
        mid();
        check("hilo_after_stall", {hi_o, lo_o}, 64'h1111_2222_3333_4444);

        // Reset in the middle of WAIT, away from the clock edge
        step();
        load(5'd12, 4'b1111, 1'b0, 1'b0, 32'h7777_7777);
        mid();
        check("rstw_stall_before", {63'd0, stall_req}, 64'd1);
        step();
        #2;
        cpu_rst = 1'b1;
        #1;
        check("rstw_stall_drop", {63'd0, stall_req}, 64'd0);
        check("rstw_hilo", {hi_o, lo_o}, 64'd0);
        check("rstw_state", {63'd0, dbg_state}, 64'd0);
        idle_in();
        step();
        step();
        cpu_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            check("rstw_no_write", {63'd0, rf_we}, 64'd0);
            check("rstw_no_stall", {63'd0, stall_req}, 64'd0);
            step();
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
